// File: rtl/rgb_sequence_monitor.sv
// Receive-side checker for the active-low RGB colour cycle: synchronises and filters the
// LED lines, then checks step order and dwell time. States: IDLE | no reference colour yet,
// ALIGN | reference colour held, waiting for a correct step, LOCKED | following the cycle.
module rgb_sequence_monitor #(
    parameter int STEP_CYCLES   = 2000000,
    parameter int TOL_CYCLES    = 1000,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        rgb_r_n_i,
    input  logic        rgb_g_n_i,
    input  logic        rgb_b_n_i,
    output logic [2:0]  color_o,
    output logic        color_valid_o,
    output logic        step_pulse_o,
    output logic        seq_error_o,
    output logic        timing_error_o,
    output logic        locked_o,
    output logic [15:0] step_count_o
);

    localparam int DMAX = STEP_CYCLES + TOL_CYCLES + 1;
    localparam int DW   = $clog2(DMAX + 1);
    localparam int SW   = $clog2(STABLE_CYCLES + 1);

    localparam logic [DW-1:0] DMAX_V   = DW'(DMAX);
    localparam logic [DW-1:0] WIN_LO   = DW'(STEP_CYCLES - TOL_CYCLES);
    localparam logic [DW-1:0] WIN_HI   = DW'(STEP_CYCLES + TOL_CYCLES);
    localparam logic [SW-1:0] STABLE_V = SW'(STABLE_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ALIGN,
        S_LOCKED
    } state_t;

    function automatic logic [2:0] succ_of(input logic [2:0] c);
        case (c)
            3'b100:  succ_of = 3'b110;
            3'b110:  succ_of = 3'b010;
            3'b010:  succ_of = 3'b011;
            3'b011:  succ_of = 3'b001;
            3'b001:  succ_of = 3'b101;
            3'b101:  succ_of = 3'b100;
            default: succ_of = 3'b000;
        endcase
    endfunction

    // Chain holds the inverted (active-high) lines so cleared flops read as "all LEDs off".
    logic [SYNC_STAGES-1:0][2:0] sync_q;
    logic [2:0]                  sample;

    logic [2:0]    cand_q, cand_d;
    logic [SW-1:0] stab_q, stab_d;
    logic [2:0]    color_q, color_d;
    logic [2:0]    prev_q, prev_d;
    logic          evt_q, evt_d;
    logic [DW-1:0] dwell_q, dwell_d;

    state_t        state_q, state_d;
    logic          step_q, step_d;
    logic          seq_q, seq_d;
    logic          tim_q, tim_d;
    logic [15:0]   count_q, count_d;

    logic          new_valid;
    logic          succ_ok;
    logic          in_win;

    assign sample = sync_q[SYNC_STAGES-1];

    always_comb begin
        cand_d  = sample;
        stab_d  = SW'(1);
        color_d = color_q;
        prev_d  = prev_q;
        evt_d   = 1'b0;
        if (sample == cand_q) begin
            stab_d = (stab_q == STABLE_V) ? stab_q : stab_q + SW'(1);
        end
        if ((stab_q == STABLE_V) && (cand_q != color_q)) begin
            evt_d   = 1'b1;
            color_d = cand_q;
            prev_d  = color_q;
        end
    end

    always_comb begin
        dwell_d = dwell_q;
        if (evt_q) begin
            dwell_d = '0;
        end else if (dwell_q != DMAX_V) begin
            dwell_d = dwell_q + DW'(1);
        end
    end

    assign new_valid = (color_q != 3'b000) && (color_q != 3'b111);
    assign succ_ok   = (succ_of(prev_q) == color_q);
    assign in_win    = (dwell_q >= WIN_LO) && (dwell_q <= WIN_HI);

    // evt_q marks the cycle after a new colour landed; prev_q/dwell_q still describe the old one.
    always_comb begin
        state_d = state_q;
        step_d  = 1'b0;
        seq_d   = 1'b0;
        tim_d   = 1'b0;
        count_d = count_q;
        case (state_q)
            S_IDLE: begin
                if (evt_q && new_valid) begin
                    state_d = S_ALIGN;
                end
            end
            S_ALIGN: begin
                if (evt_q) begin
                    if (!new_valid) begin
                        seq_d   = 1'b1;
                        state_d = S_IDLE;
                    end else if (succ_ok) begin
                        state_d = S_LOCKED;
                    end else begin
                        seq_d = 1'b1;
                    end
                end
            end
            S_LOCKED: begin
                if (evt_q) begin
                    if (!new_valid) begin
                        seq_d   = 1'b1;
                        state_d = S_IDLE;
                    end else if (succ_ok) begin
                        step_d  = 1'b1;
                        count_d = count_q + 16'd1;
                        tim_d   = !in_win;
                    end else begin
                        seq_d   = 1'b1;
                        state_d = S_ALIGN;
                    end
                end else if (dwell_q == DMAX_V) begin
                    tim_d   = 1'b1;
                    state_d = S_ALIGN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q  <= '0;
            cand_q  <= '0;
            stab_q  <= '0;
            color_q <= '0;
            prev_q  <= '0;
            evt_q   <= 1'b0;
            dwell_q <= '0;
            state_q <= S_IDLE;
            step_q  <= 1'b0;
            seq_q   <= 1'b0;
            tim_q   <= 1'b0;
            count_q <= '0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], ~{rgb_r_n_i, rgb_g_n_i, rgb_b_n_i}};
            cand_q  <= cand_d;
            stab_q  <= stab_d;
            color_q <= color_d;
            prev_q  <= prev_d;
            evt_q   <= evt_d;
            dwell_q <= dwell_d;
            state_q <= state_d;
            step_q  <= step_d;
            seq_q   <= seq_d;
            tim_q   <= tim_d;
            count_q <= count_d;
        end
    end

    assign color_o        = color_q;
    assign color_valid_o  = (color_q != 3'b000) && (color_q != 3'b111);
    assign step_pulse_o   = step_q;
    assign seq_error_o    = seq_q;
    assign timing_error_o = tim_q;
    assign locked_o       = (state_q == S_LOCKED);
    assign step_count_o   = count_q;

endmodule

// File: tb/tb_rgb_sequence_monitor.sv
// Scoreboard bench for rgb_sequence_monitor: a colour-level model pushes the expected
// outcome of every colour change or stall; a monitor pops and compares on each DUT event.
module tb_rgb_sequence_monitor;

    localparam int STEP   = 100;
    localparam int TOL    = 4;
    localparam int SYNC   = 2;
    localparam int STABLE = 4;
    localparam int DMAX   = STEP + TOL + 1;

    localparam logic [2:0] OFF = 3'b000;
    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b110;
    localparam logic [2:0] GRN = 3'b010;
    localparam logic [2:0] CYN = 3'b011;
    localparam logic [2:0] BLU = 3'b001;
    localparam logic [2:0] MAG = 3'b101;
    localparam logic [2:0] WHT = 3'b111;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rgb_r_n = 1'b1;
    logic        rgb_g_n = 1'b1;
    logic        rgb_b_n = 1'b1;
    logic [2:0]  color;
    logic        color_valid;
    logic        step_pulse;
    logic        seq_error;
    logic        timing_error;
    logic        locked;
    logic [15:0] step_count;

    always #5 clk = ~clk;

    rgb_sequence_monitor #(
        .STEP_CYCLES  (STEP),
        .TOL_CYCLES   (TOL),
        .SYNC_STAGES  (SYNC),
        .STABLE_CYCLES(STABLE)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .rgb_r_n_i     (rgb_r_n),
        .rgb_g_n_i     (rgb_g_n),
        .rgb_b_n_i     (rgb_b_n),
        .color_o       (color),
        .color_valid_o (color_valid),
        .step_pulse_o  (step_pulse),
        .seq_error_o   (seq_error),
        .timing_error_o(timing_error),
        .locked_o      (locked),
        .step_count_o  (step_count)
    );

    typedef struct packed {
        logic [2:0]  color;
        logic        step;
        logic        seq;
        logic        tim;
        logic        locked;
        logic [15:0] count;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // model state: 0 idle, 1 align, 2 locked
    int          m_st  = 0;
    logic [2:0]  m_cur = OFF;
    int          m_acc = 0;
    logic [15:0] m_cnt = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [2:0] next_color(input logic [2:0] c);
        case (c)
            RED:     return YEL;
            YEL:     return GRN;
            GRN:     return CYN;
            CYN:     return BLU;
            BLU:     return MAG;
            MAG:     return RED;
            default: return OFF;
        endcase
    endfunction

    task automatic drive(input logic [2:0] c);
        {rgb_r_n, rgb_g_n, rgb_b_n} = ~c;
    endtask

    task automatic model_event(input logic [2:0] c, input int dwell);
        exp_t e;
        logic v;
        logic ok;
        v = (c != OFF) && (c != WHT);
        ok = (next_color(m_cur) == c);
        e = '0;
        e.color = c;
        case (m_st)
            0: if (v) m_st = 1;
            1: begin
                if (!v) begin e.seq = 1'b1; m_st = 0; end
                else if (ok) m_st = 2;
                else e.seq = 1'b1;
            end
            default: begin
                if (!v) begin e.seq = 1'b1; m_st = 0; end
                else if (ok) begin
                    e.step = 1'b1;
                    m_cnt  = m_cnt + 16'd1;
                    e.tim  = (dwell < STEP - TOL) || (dwell > STEP + TOL);
                end else begin
                    e.seq = 1'b1;
                    m_st  = 1;
                end
            end
        endcase
        e.locked = (m_st == 2);
        e.count  = m_cnt;
        sb.push_back(e);
    endtask

    // Dwell seen at an event is the previous hold minus one (counter restarts when the event is processed).
    task automatic hold(input logic [2:0] c, input int n);
        exp_t e;
        if (c != m_cur) begin
            model_event(c, (m_acc - 1 > DMAX) ? DMAX : m_acc - 1);
            m_acc = 0;
            m_cur = c;
        end
        if (m_st == 2 && n - 1 > DMAX) begin
            e = '0;
            e.color = m_cur;
            e.tim   = 1'b1;
            e.count = m_cnt;
            sb.push_back(e);
            m_st = 1;
        end
        drive(c);
        repeat (n) @(posedge clk);
        #1;
        m_acc += n;
    endtask

    task automatic glitch(input logic [2:0] g, input int n);
        drive(g);
        repeat (n) @(posedge clk);
        #1;
        drive(m_cur);
        m_acc += n;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_color"}, color, OFF);
        chk({tag, "_valid"}, color_valid, 0);
        chk({tag, "_step"}, step_pulse, 0);
        chk({tag, "_seq"}, seq_error, 0);
        chk({tag, "_tim"}, timing_error, 0);
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_count"}, step_count, 0);
    endtask

    task automatic model_reset();
        m_st  = 0;
        m_cur = OFF;
        m_acc = 0;
        m_cnt = '0;
    endtask

    initial begin : monitor
        logic [2:0] last_col;
        logic       chg;
        exp_t       e;
        last_col = OFF;
        chg = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                last_col = OFF;
                chg = 1'b0;
            end else begin
                if (chg || step_pulse || seq_error || timing_error) begin
                    if (sb.size() == 0) begin
                        chk("sb_underflow", 0, 1);
                    end else begin
                        e = sb.pop_front();
                        chk("ev_color", color, e.color);
                        chk("ev_step", step_pulse, e.step);
                        chk("ev_seq", seq_error, e.seq);
                        chk("ev_tim", timing_error, e.tim);
                        chk("ev_locked", locked, e.locked);
                        chk("ev_count", step_count, e.count);
                    end
                end
                chg = (color != last_col);
                last_col = color;
            end
        end
    end

    initial begin
        drive(OFF);
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_reset_outputs("rst0");
        rst = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;

        hold(RED, 100);
        hold(YEL, 100);
        hold(GRN, 100);
        chk("lock_locked", locked, 1);
        chk("lock_count", step_count, 1);

        hold(CYN, 100);
        hold(BLU, 100);
        hold(MAG, 100);
        for (int k = 0; k < 2; k++) begin
            hold(RED, 100);
            hold(YEL, 100);
            hold(GRN, 100);
            hold(CYN, 100);
            hold(BLU, 100);
            hold(MAG, 100);
        end
        hold(RED, 100);
        chk("loop_count", step_count, 17);
        chk("loop_locked", locked, 1);

        hold(YEL, 100);
        hold(GRN, 50);
        glitch(RED, 3);
        hold(GRN, 47);
        chk("glitch_color", color, GRN);

        hold(CYN, 100);
        hold(BLU, 97);
        hold(MAG, 96);
        hold(RED, 105);
        hold(YEL, 106);
        hold(GRN, 95);
        hold(CYN, 100);
        chk("bound_locked", locked, 1);

        hold(MAG, 100);
        chk("jump_locked", locked, 0);
        hold(GRN, 100);
        hold(CYN, 100);
        chk("relock_locked", locked, 1);
        hold(BLU, 100);
        hold(MAG, 100);
        hold(WHT, 100);
        chk("white_valid", color_valid, 0);
        hold(RED, 100);
        hold(YEL, 100);
        hold(GRN, 100);
        hold(CYN, 150);
        chk("stall_locked", locked, 0);

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst1");
        drive(OFF);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;

        hold(RED, 100);
        hold(YEL, 100);
        hold(GRN, 30);
        chk("post_rst_count", step_count, 1);

        repeat (20) @(posedge clk);
        #1;
        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
